// File: rtl/regfile_bytewrite_sb_if.sv
// Decode/writeback bus for regfile_bytewrite_sb: read selects, write port,
// reservation request and the registered read results.
interface regfile_bytewrite_sb_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0]   I_rA_select;
  logic [ADDR_W-1:0]   I_rB_select;
  logic [ADDR_W-1:0]   I_rD_select;
  logic [DATA_W-1:0]   I_rD_in;
  logic                I_rD_write;
  logic [DATA_W/8-1:0] I_rD_mask;
  logic                I_res_valid;
  logic [ADDR_W-1:0]   I_res_select;
  logic [DATA_W-1:0]   O_rA_out;
  logic [DATA_W-1:0]   O_rB_out;
  logic                O_rA_busy;
  logic                O_rB_busy;

  // Decode/writeback side
  modport master (
    output I_rA_select, I_rB_select, I_rD_select, I_rD_in, I_rD_write,
           I_rD_mask, I_res_valid, I_res_select,
    input  O_rA_out, O_rB_out, O_rA_busy, O_rB_busy
  );

  // Register file side
  modport slave (
    input  I_rA_select, I_rB_select, I_rD_select, I_rD_in, I_rD_write,
           I_rD_mask, I_res_valid, I_res_select,
    output O_rA_out, O_rB_out, O_rA_busy, O_rB_busy
  );
endinterface

// File: rtl/regfile_bytewrite_sb.sv
// Parametrised register file: two registered read ports with write-through
// forwarding, one byte-masked write port, and a per-register busy scoreboard.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero (writes and
// reservations of index 0 ignored, busy[0] always 0).
module regfile_bytewrite_sb #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                    I_clk,
  input  logic                    I_reset_n,
  input  logic                    I_enable,
  regfile_bytewrite_sb_if.slave   rf
);
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned LANES    = DATA_W / 8;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   rA_q, rB_q;
  logic                rA_busy_q, rB_busy_q;
  logic                wr_eff, res_eff;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_eff  = rf.I_rD_write && (|rf.I_rD_mask) && (rf.I_rD_select != '0);
  assign res_eff = rf.I_res_valid && (rf.I_res_select != '0);
`else
  assign wr_eff  = rf.I_rD_write && (|rf.I_rD_mask);
  assign res_eff = rf.I_res_valid;
`endif

  // Next register contents and scoreboard; the read ports sample these
  // post-update values, which gives lane-wise write-through forwarding and
  // the set-wins-over-clear busy rule for free.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    busy_d = busy_q;
    if (wr_eff) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (rf.I_rD_mask[k]) begin
          regs_d[rf.I_rD_select][8*k +: 8] = rf.I_rD_in[8*k +: 8];
        end
      end
      busy_d[rf.I_rD_select] = 1'b0;
    end
    if (res_eff) begin
      busy_d[rf.I_res_select] = 1'b1;
    end
  end

  // State and registered read outputs; enable low freezes everything
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      rA_q      <= '0;
      rB_q      <= '0;
      rA_busy_q <= 1'b0;
      rB_busy_q <= 1'b0;
    end else if (I_enable) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q    <= busy_d;
      rA_q      <= regs_d[rf.I_rA_select];
      rB_q      <= regs_d[rf.I_rB_select];
      rA_busy_q <= busy_d[rf.I_rA_select];
      rB_busy_q <= busy_d[rf.I_rB_select];
    end
  end

  assign rf.O_rA_out  = rA_q;
  assign rf.O_rB_out  = rB_q;
  assign rf.O_rA_busy = rA_busy_q;
  assign rf.O_rB_busy = rB_busy_q;
endmodule

// File: tb/tb_regfile_bytewrite_sb.sv
// Directed self-checking bench for regfile_bytewrite_sb (DATA_W=16, ADDR_W=3).
module tb_regfile_bytewrite_sb;
  logic clk;
  logic rst_n;
  logic enable;
  int   checks;
  int   errors;

  regfile_bytewrite_sb_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_bytewrite_sb #(.DATA_W(16), .ADDR_W(3)) dut (
    .I_clk     (clk),
    .I_reset_n (rst_n),
    .I_enable  (enable),
    .rf        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Set all inputs for the next edge
  task automatic drive(input logic en, input logic wr, input logic [2:0] d,
                       input logic [15:0] din, input logic [1:0] mask,
                       input logic res, input logic [2:0] rsel,
                       input logic [2:0] a, input logic [2:0] b);
    enable           = en;
    bus.I_rD_write   = wr;
    bus.I_rD_select  = d;
    bus.I_rD_in      = din;
    bus.I_rD_mask    = mask;
    bus.I_res_valid  = res;
    bus.I_res_select = rsel;
    bus.I_rA_select  = a;
    bus.I_rB_select  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0);
    #2;
    chk("rst_A", bus.O_rA_out, 16'h0000);
    chk("rst_B", bus.O_rB_out, 16'h0000);
    chk("rst_Abusy", {15'd0, bus.O_rA_busy}, 16'h0000);
    chk("rst_Bbusy", {15'd0, bus.O_rB_busy}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Write r3=BEEF, reserve r5, forwarded read
    drive(1'b1, 1'b1, 3'd3, 16'hBEEF, 2'b11, 1'b1, 3'd5, 3'd3, 3'd5);
    tick();
    chk("fwd_r3", bus.O_rA_out, 16'hBEEF);
    chk("res_r5_busy", {15'd0, bus.O_rB_busy}, 16'h0001);

    // Reset between edges: outputs clear immediately
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd3, 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_A", bus.O_rA_out, 16'h0000);
    chk("midrst_Bbusy", {15'd0, bus.O_rB_busy}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("postrst_r3", bus.O_rA_out, 16'h0000);
    chk("postrst_r5_busy", {15'd0, bus.O_rB_busy}, 16'h0000);

    // Byte lanes on r2
    drive(1'b1, 1'b1, 3'd2, 16'h1234, 2'b11, 1'b0, 3'd0, 3'd2, 3'd0);
    tick();
    chk("r2_full", bus.O_rA_out, 16'h1234);
    drive(1'b1, 1'b1, 3'd2, 16'hABCD, 2'b10, 1'b0, 3'd0, 3'd2, 3'd0);
    tick();
    chk("r2_hi_fwd", bus.O_rA_out, 16'hAB34);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd2, 3'd2, 3'd2);
    tick();
    chk("r2_hi_read", bus.O_rA_out, 16'hAB34);
    chk("r2_res_busy", {15'd0, bus.O_rB_busy}, 16'h0001);
    drive(1'b1, 1'b1, 3'd2, 16'hFFFF, 2'b00, 1'b0, 3'd0, 3'd2, 3'd2);
    tick();
    chk("r2_mask0", bus.O_rA_out, 16'hAB34);
    chk("r2_mask0_busy", {15'd0, bus.O_rA_busy}, 16'h0001);

    // Forwarding to both ports on r1
    drive(1'b1, 1'b1, 3'd1, 16'h5A5A, 2'b11, 1'b0, 3'd0, 3'd1, 3'd1);
    tick();
    chk("fwd_A", bus.O_rA_out, 16'h5A5A);
    chk("fwd_B", bus.O_rB_out, 16'h5A5A);

    // Low-lane merge on r7
    drive(1'b1, 1'b1, 3'd7, 16'h1234, 2'b11, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();
    drive(1'b1, 1'b1, 3'd7, 16'hABCD, 2'b01, 1'b0, 3'd0, 3'd7, 3'd0);
    tick();
    chk("r7_lo_fwd", bus.O_rA_out, 16'h12CD);

    // Scoreboard on r4
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd4, 3'd4, 3'd0);
    tick();
    chk("r4_res_same", {15'd0, bus.O_rA_busy}, 16'h0001);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd4, 3'd4);
    tick();
    chk("r4_busyA", {15'd0, bus.O_rA_busy}, 16'h0001);
    chk("r4_busyB", {15'd0, bus.O_rB_busy}, 16'h0001);
    drive(1'b1, 1'b1, 3'd4, 16'h0044, 2'b11, 1'b1, 3'd4, 3'd4, 3'd0);
    tick();
    chk("r4_setwins", {15'd0, bus.O_rA_busy}, 16'h0001);
    drive(1'b1, 1'b1, 3'd4, 16'h4444, 2'b11, 1'b0, 3'd0, 3'd4, 3'd0);
    tick();
    chk("r4_clear", {15'd0, bus.O_rA_busy}, 16'h0000);
    chk("r4_val", bus.O_rA_out, 16'h4444);

    // Enable freeze
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd6, 3'd1);
    tick();
    chk("pre_freeze_A", bus.O_rA_out, 16'h0000);
    chk("pre_freeze_B", bus.O_rB_out, 16'h5A5A);
    drive(1'b0, 1'b1, 3'd6, 16'hFFFF, 2'b11, 1'b1, 3'd6, 3'd2, 3'd4);
    tick();
    chk("freeze_A", bus.O_rA_out, 16'h0000);
    chk("freeze_B", bus.O_rB_out, 16'h5A5A);
    chk("freeze_Abusy", {15'd0, bus.O_rA_busy}, 16'h0000);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd6, 3'd6);
    tick();
    chk("r6_unchanged", bus.O_rA_out, 16'h0000);
    chk("r6_busy_unch", {15'd0, bus.O_rB_busy}, 16'h0000);

    // Register 0 behaviour
    drive(1'b1, 1'b1, 3'd0, 16'h7777, 2'b11, 1'b1, 3'd0, 3'd0, 3'd0);
    tick();
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();
`ifdef REGFILE_ZERO_REG_EN
    chk("r0_val", bus.O_rA_out, 16'h0000);
    chk("r0_busy", {15'd0, bus.O_rA_busy}, 16'h0000);
`else
    chk("r0_val", bus.O_rA_out, 16'h7777);
    chk("r0_busy", {15'd0, bus.O_rA_busy}, 16'h0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_bytewrite_sb.md
Name: regfile_bytewrite_sb

Overview:
- Parametrised successor of the 8x16 CPU register file.
- Adds generic width and depth, per-byte write masks, and write-to-read forwarding.
- Adds a busy scoreboard so decode can stall on registers with pending writebacks.
- Sits between decode (read selects, reservations) and writeback (rD write); two registered read ports, one write port.

Parameters:
DATA_W, 16, register width in bits; must be a multiple of 8, minimum 8
ADDR_W, 3, select width; register count NUM_REGS = 2**ADDR_W (derived localparam, not overridable)

Ports:
I_clk  input  1  clock, all state updates on rising edge
I_reset_n  input  1  asynchronous active-low reset
I_enable  input  1  global advance; 0 freezes all state and outputs
I_rA_select  input  ADDR_W  read port A register index
I_rB_select  input  ADDR_W  read port B register index
I_rD_select  input  ADDR_W  write port register index
I_rD_in  input  DATA_W  write data
I_rD_write  input  1  write request
I_rD_mask  input  DATA_W/8  byte-lane write enables; bit k covers bits [8k+7:8k]
I_res_valid  input  1  reserve request; marks I_res_select busy
I_res_select  input  ADDR_W  register index to reserve
O_rA_out  output  DATA_W  registered read data, port A
O_rB_out  output  DATA_W  registered read data, port B
O_rA_busy  output  1  registered busy flag for the register on port A
O_rB_busy  output  1  registered busy flag for the register on port B

Behaviour:
- Reset (I_reset_n=0, asynchronous): all registers 0; all busy bits 0; O_rA_out, O_rB_out, O_rA_busy, O_rB_busy all 0. Reset overrides I_enable. Release is synchronous to the next rising edge.
- I_enable=0: no write, no reservation, no busy clear; outputs hold their previous values.
- Write is effective when I_enable=1, I_rD_write=1 and I_rD_mask != 0.
  - Only lanes with mask bit 1 take I_rD_in; all other lanes keep their old value.
  - Mask all zero with I_rD_write=1: no write and no busy clear.
- Read latency is 1 cycle. At each enabled edge, O_rX_out <= merged value of register[I_rX_select]. The merged value includes the same-cycle effective write to that index, lane by lane (write-through forwarding).
  - Example: reg holds 0x1234; write 0xABCD with mask 01 and the same read index -> O_rX_out=0x12CD on that edge.
- Both ports may select the same register; both return identical data.
- Busy scoreboard, one bit per register, updated at each enabled edge:
  - Effective write to index d clears busy[d].
  - I_res_valid=1 sets busy[I_res_select].
  - Same index written and reserved in the same cycle: set wins (new producer), busy stays 1.
  - Reserving an already-busy register: stays 1, no error.
- O_rX_busy <= post-update busy bit of I_rX_select. A register cleared this cycle reads 0; one reserved this cycle reads 1.
- Reset during a pending reservation clears all busy bits; pending writebacks are the issuer's responsibility.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes to index 0 are ignored (no forwarding of that write).
  - Reads of index 0 return 0.
  - Reservations of index 0 are ignored; busy[0] is always 0.
- Undefined: register 0 is an ordinary register, identical to all others.

Test Plan:
- Reset mid-operation: write 0xBEEF to r3 and reserve r5, then assert I_reset_n=0 between edges. Required: outputs 0 immediately (before next edge); read r3 after release -> 0x0000; O_busy for r5 = 0.
- Byte lanes: r2=0x1234, write 0xABCD with mask 10. Next cycle read r2 -> 0xAB34. Then write with mask 00 -> r2 unchanged at 0xAB34.
- Forwarding: r1=0x0000, same edge writes 0x5A5A (mask 11) and reads r1 on both A and B. Required: O_rA_out = O_rB_out = 0x5A5A on that edge.
- Scoreboard: reserve r4 -> O_busy(r4)=1 on the following reads. Write r4 with reserve r4 in the same cycle -> busy stays 1. Write r4 alone -> busy 0 on that same edge's read.
- Enable freeze: I_enable=0 with write 0xFFFF to r6 and reserve r6. Required: outputs hold; r6 unchanged; busy[r6] unchanged.
- REGFILE_ZERO_REG_EN defined: write 0x7777 to r0 and reserve r0. Required: read r0 -> 0x0000, busy 0. Without the macro: read r0 -> 0x7777, busy 1.
